// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcode, ALU-control and state encodings for the multicycle controller
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle main controller sequencing ALU, memory, PC and register file
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t state, next_state;
    logic   rdy;

    assign rdy       = USE_MEM_READY ? mem_ready : 1'b1;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   next_state = rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // Gated by reset so a write in flight is withdrawn the instant reset rises.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = rdy;
                    PCWrite = rdy;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMM_SH;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_ADDIWB: RegWrite = 1'b1;
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    mc_control_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control word each phase of an instruction should present.
    function automatic logic [16:0] exp_out(input int ph, input bit rdy, input bit ill);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        bit m2r = 0, rdst = 0, rw = 0, sa = 0;
        logic [1:0] sb = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (ph)
            0:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, ill && (ph == 1)};
    endfunction

    // Runs one instruction from FETCH; entered and left just after a falling edge.
    task automatic run_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits, input bit rnd);
        int phases[$];
        int base;
        bit ill;
        int cycles;
        int waits;
        int fw;
        int mw;
        bit mr;
        bit waitst;
        ill = 0; cycles = 0; waits = 0; fw = fetch_waits; mw = mem_waits;
        case (op)
            6'b100011: begin phases = '{0, 1, 2, 3, 4}; base = 5; end
            6'b101011: begin phases = '{0, 1, 2, 5};    base = 4; end
            6'b000000: begin phases = '{0, 1, 6, 7};    base = 4; end
            6'b001000: begin phases = '{0, 1, 9, 10};   base = 4; end
            6'b000100: begin phases = '{0, 1, 8};       base = 3; end
            6'b000010: begin phases = '{0, 1, 11};      base = 3; end
            default:   begin phases = '{0, 1};          base = 2; ill = 1; end
        endcase
        opcode = op;
        foreach (phases[i]) begin
            waitst = (phases[i] == 0) || (phases[i] == 3) || (phases[i] == 5);
            forever begin
                if (rnd)                          mr = ($urandom_range(0, 3) != 0);
                else if (!waitst)                 mr = $urandom_range(0, 1) != 0;
                else if (phases[i] == 0 && fw > 0) begin mr = 0; fw--; end
                else if (phases[i] != 0 && mw > 0) begin mr = 0; mw--; end
                else                              mr = 1;
                mem_ready = mr;
                #1;
                check_eq("state", {28'd0, state_dbg}, phases[i]);
                check_eq("outputs", {15'd0, outs}, {15'd0, exp_out(phases[i], mr, ill)});
                check_eq("rd_wr_excl", {31'd0, MemRead & MemWrite}, 0);
                check_eq("rw_pc_excl", {31'd0, RegWrite & (PCWrite | PCWriteCond)}, 0);
                cycles++;
                @(negedge clk);
                if (waitst && !mr) waits++;
                else break;
            end
        end
        check_eq("cycle_count", cycles, base + waits);
    endtask

    localparam logic [5:0] LEGAL [6] = '{6'b100011, 6'b101011, 6'b000000,
                                         6'b001000, 6'b000100, 6'b000010};

    initial begin
        logic [5:0] op;
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {15'd0, outs}, 0);
        check_eq("reset_state", {28'd0, state_dbg}, 0);
        reset = 1'b0;

        run_instr(6'b100011, 0, 0, 0);
        run_instr(6'b101011, 0, 3, 0);
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000010, 2, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
        run_instr(6'b001000, 0, 0, 0);
        run_instr(6'b100011, 1, 2, 0);

        // Reset lands while a store is waiting in MEMWR.
        opcode = 6'b101011; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_eq("pre_reset_state", {28'd0, state_dbg}, 5);
        check_eq("pre_reset_memwrite", {31'd0, MemWrite}, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_memwrite", {31'd0, MemWrite}, 0);
        check_eq("async_state", {28'd0, state_dbg}, 0);
        check_eq("async_outputs", {15'd0, outs}, 0);
        @(negedge clk);
        check_eq("held_outputs", {15'd0, outs}, 0);
        reset = 1'b0;
        run_instr(6'b000010, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else                           op = LEGAL[$urandom_range(0, 5)];
            run_instr(op, 0, 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
